// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// saturating counter update and BTB tag width.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] next;
        next = cnt;
        if (taken && cnt != ST)
            next = cnt + 2'd1;
        else if (!taken && cnt != SNT)
            next = cnt - 2'd1;
        return next;
    endfunction

    // Word-aligned PCs: two offset bits and IDX_W index bits are not stored.
    function automatic int tag_width(input int idx_w);
        return 30 - idx_w;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: combinational hit/target read,
// synchronous write; only the valid bits are reset.
module bp_btb
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W = $clog2(ENTRIES),
    localparam int TAG_W = tag_width(IDX_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];

    assign hit       = valid[rd_idx] & (tag[rd_idx] == rd_tag);
    assign rd_target = target[rd_idx];

    always_ff @(posedge clk) begin
        if (rst)
            valid <= '0;
        else if (wr_en)
            valid[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare branch predictor: IF-stage lookup, EX-stage resolve and
// training, plus saturating branch and misprediction counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int          ENTRIES      = 64,
    parameter int          HIST_BITS    = 0,
    parameter logic [1:0]  COUNTER_INIT = 2'b01,
    localparam int         IDX_W        = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             ex_valid,
    input  logic             ex_cond,
    input  logic [31:0]      ex_pc,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispred_count
);

    localparam int TAG_W = tag_width(IDX_W);
    localparam int GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic [1:0]       cnt [ENTRIES];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] btb_idx;
    logic             btb_hit;
    logic [31:0]      btb_target;

    assign btb_idx = if_pc[IDX_W+1:2];

    always_comb begin
        if (HIST_BITS > 0)
            pred_idx = btb_idx ^ IDX_W'(ghr);
        else
            pred_idx = btb_idx;
    end

    bp_btb #(.ENTRIES(ENTRIES)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (btb_idx),
        .rd_tag    (if_pc[31:IDX_W+2]),
        .hit       (btb_hit),
        .rd_target (btb_target),
        .wr_en     (ex_valid & ex_taken),
        .wr_idx    (ex_pc[IDX_W+1:2]),
        .wr_tag    (ex_pc[31:IDX_W+2]),
        .wr_target (ex_target)
    );

    assign pred_taken  = btb_hit & cnt[pred_idx][1];
    assign pred_target = pred_taken ? btb_target : if_pc + 32'd4;

    assign mispredict  = ex_valid & ((ex_taken != ex_pred_taken) |
                                     (ex_taken & (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    // Training uses the carried ex_idx so the entry predicted from is the one trained.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt[i] <= COUNTER_INIT;
            ghr           <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
        end else if (ex_valid) begin
            if (ex_cond)
                cnt[ex_idx] <= sat_update(cnt[ex_idx], ex_taken);
            else
                cnt[ex_idx] <= ST;
            if (HIST_BITS > 0 && ex_cond)
                ghr <= GHR_W'({ghr, ex_taken});
            if (branch_count != '1)
                branch_count <= branch_count + 32'd1;
            if (mispredict && mispred_count != '1)
                mispred_count <= mispred_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random/directed bench for branch_predictor (gshare, 4 history bits)
// against an arithmetic reference model of the predictor tables.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int HIST    = 4;
    localparam int IDX_W   = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic [IDX_W-1:0] pred_idx;
    logic             ex_valid, ex_cond, ex_pred_taken, ex_taken;
    logic [31:0]      ex_pc, ex_pred_target, ex_target;
    logic [IDX_W-1:0] ex_idx;
    logic             mispredict;
    logic [31:0]      redirect_pc, branch_count, mispred_count;

    branch_predictor #(.ENTRIES(ENTRIES), .HIST_BITS(HIST), .COUNTER_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_idx(pred_idx), .ex_valid(ex_valid),
        .ex_cond(ex_cond), .ex_pc(ex_pc), .ex_idx(ex_idx),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .ex_target(ex_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .branch_count(branch_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic             pt;
        logic [31:0]      ptg;
        logic [IDX_W-1:0] pidx;
        logic             mp;
        logic             ev;
        logic [31:0]      rd;
        logic [31:0]      bc;
        logic [31:0]      mc;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc_id     = 0;

    // Reference model: plain integer tables
    int          m_cnt [ENTRIES];
    bit          m_v   [ENTRIES];
    logic [31:0] m_tg  [ENTRIES];
    logic [31:0] m_tt  [ENTRIES];
    int          m_ghr;
    longint      m_bc, m_mc;

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic m_predict(input logic [31:0] pc, output logic pt,
                             output logic [31:0] ptg, output int pidx);
        int b;
        b    = bidx(pc);
        pidx = b ^ m_ghr;
        pt   = m_v[b] && (m_tg[b] == tagof(pc)) && (m_cnt[pidx] >= 2);
        ptg  = pt ? m_tt[b] : pc + 32'd4;
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_cnt[i] = 1;
            m_v[i]   = 0;
        end
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    task automatic check(input int id, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL cycle %0d %s: got %h, required %h", id, name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.id, "pred_taken", 32'(pred_taken), 32'(e.pt));
                check(e.id, "pred_target", pred_target, e.ptg);
                check(e.id, "pred_idx", 32'(pred_idx), 32'(e.pidx));
                check(e.id, "mispredict", 32'(mispredict), 32'(e.mp));
                if (e.ev)
                    check(e.id, "redirect_pc", redirect_pc, e.rd);
                check(e.id, "branch_count", branch_count, e.bc);
                check(e.id, "mispred_count", mispred_count, e.mc);
            end
        end
    end

    // One clock cycle: drive, queue expectation, take the edge, train the model.
    task automatic cycle(input bit r, input logic [31:0] pc, input bit ev, input bit cond,
                         input int eidx, input bit ept, input logic [31:0] eptg,
                         input logic [31:0] epc, input bit et, input logic [31:0] etg,
                         input bit chk, output logic mp_seen);
        exp_t e;
        int   pidx, ix;
        logic mp;
        rst = r; if_pc = pc; ex_valid = ev; ex_cond = cond; ex_idx = IDX_W'(eidx);
        ex_pred_taken = ept; ex_pred_target = eptg; ex_pc = epc;
        ex_taken = et; ex_target = etg;
        m_predict(pc, e.pt, e.ptg, pidx);
        mp     = ev && ((et != ept) || (et && etg != eptg));
        e.id   = cyc_id;
        e.pidx = IDX_W'(pidx);
        e.mp   = mp;
        e.ev   = ev;
        e.rd   = et ? etg : epc + 32'd4;
        e.bc   = m_bc[31:0];
        e.mc   = m_mc[31:0];
        if (chk) q.push_back(e);
        #3 mp_seen = mispredict;
        @(posedge clk);
        if (r) m_reset();
        else if (ev) begin
            ix = eidx % ENTRIES;
            if (cond) begin
                m_cnt[ix] = et ? ((m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3)
                               : ((m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0);
                m_ghr = (m_ghr * 2 + int'(et)) % (1 << HIST);
            end else
                m_cnt[ix] = 3;
            if (et) begin
                m_v[bidx(epc)]  = 1;
                m_tg[bidx(epc)] = tagof(epc);
                m_tt[bidx(epc)] = etg;
            end
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
        cyc_id++;
        #1;
    endtask

    task automatic idle(input logic [31:0] pc);
        logic d;
        cycle(0, pc, 0, 0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    // Fetch and resolve the same branch in one cycle, carrying the model's prediction.
    task automatic resolve(input logic [31:0] pc, input bit cond, input bit et,
                           input logic [31:0] tgt, output logic mp_seen);
        logic        pt;
        logic [31:0] ptg;
        int          pidx;
        m_predict(pc, pt, ptg, pidx);
        cycle(0, pc, 1, cond, pidx, pt, ptg, pc, et, tgt, 1, mp_seen);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic        d;
        logic [31:0] pool [8];
        logic [31:0] tgts [4];
        pool = '{32'h0040_0020, 32'h0040_0030, 32'h0040_0130, 32'h0040_0040,
                 32'h0040_0100, 32'h0040_0224, 32'h1000_0020, 32'h0040_0010};
        tgts = '{32'h0040_0000, 32'h0040_1000, 32'h0040_0100, 32'h0040_0080};
        m_reset();
        @(posedge clk); #1;

        cycle(1, 32'h0040_0010, 1, 1, 5, 0, 0, 32'h0040_0020, 1, 32'h0040_0000, 0, d);
        cycle(1, 32'h0040_0010, 1, 1, 5, 0, 0, 32'h0040_0020, 1, 32'h0040_0000, 1, d);
        idle(32'h0040_0010);

        resolve(32'h0040_0020, 1, 1, 32'h0040_0000, d);
        resolve(32'h0040_0020, 1, 1, 32'h0040_0000, d);
        idle(32'h0040_0020);
        for (int i = 0; i < 3; i++) resolve(32'h0040_0020, 1, 0, 32'h0040_0000, d);
        idle(32'h0040_0020);

        resolve(32'h0040_0030, 0, 1, 32'h0040_1000, d);
        idle(32'h0040_0030);
        idle(32'h0040_0130);

        cycle(1, 32'h0040_0030, 1, 0, 12, 0, 0, 32'h0040_0030, 1, 32'h0040_2000, 1, d);
        idle(32'h0040_0030);
        idle(32'h0040_0020);

        for (int i = 0; i < 20; i++) begin
            resolve(32'h0040_0040, 1, (i % 2) == 0, 32'h0040_0100, d);
            if (i >= 12) check(cyc_id - 1, "alt_pattern_mispredict", 32'(d), 32'd0);
        end
        idle(32'h0040_0040);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, epc, tg, eptg;
            bit          r, ev, cond, et, ept;
            pc  = pool[$urandom_range(7)];
            epc = pool[$urandom_range(7)];
            tg  = ($urandom_range(4) == 0) ? $urandom() : tgts[$urandom_range(3)];
            et  = $urandom_range(1) != 0;
            cond = $urandom_range(3) != 0;
            if ($urandom_range(1) == 0) begin
                resolve(pc, cond, et, tg, d);
            end else begin
                r    = $urandom_range(39) == 0;
                ev   = $urandom_range(3) != 0;
                ept  = $urandom_range(1) != 0;
                eptg = ($urandom_range(1) == 0) ? tg : tgts[$urandom_range(3)];
                cycle(r, pc, ev, cond, int'($urandom_range(ENTRIES - 1)), ept, eptg,
                      epc, et, tg, 1, d);
            end
        end
        idle(32'h0040_0020);
        @(posedge clk); #1;
        check(cyc_id, "scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage MIPS pipeline; replaces the static predict-not-taken scheme (flush on taken branch).
- Direct-mapped branch history table (BHT) of 2-bit saturating counters, plus a tagged branch target buffer (BTB).
- IF stage performs the lookup combinationally from the fetch PC; EX stage resolves branches and trains the tables in the same cycle.
- Optional gshare indexing is set by parameter; 32-bit saturating performance counters track branches and mispredictions.

Parameters:
- ENTRIES, 64, BHT/BTB depth; power of 2, range 4..1024.
- HIST_BITS, 0, global history length; 0 = bimodal, 1..IDX_W = gshare.
- COUNTER_INIT, 2'b01, counter value after reset (weakly not-taken).
- IDX_W, $clog2(ENTRIES), derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch PC.
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  32  predicted next PC.
- pred_idx  out  IDX_W  BHT index used; carried down the pipeline.
- ex_valid  in  1  control-transfer instruction resolving in EX this cycle.
- ex_cond  in  1  1 = conditional branch, 0 = unconditional jump.
- ex_pc  in  32  PC of the resolving instruction.
- ex_idx  in  IDX_W  pred_idx carried from IF.
- ex_pred_taken  in  1  carried prediction.
- ex_pred_target  in  32  carried prediction target.
- ex_taken  in  1  actual outcome.
- ex_target  in  32  actual target.
- mispredict  out  1  redirect required; flush IF/ID and ID/EX.
- redirect_pc  out  32  correct next PC.
- branch_count  out  32  resolved-branch counter.
- mispred_count  out  32  misprediction counter.

Behaviour:
- Reset (rst=1 at clk edge):
  - All BTB valid bits = 0.
  - All counters = COUNTER_INIT.
  - GHR = 0.
  - branch_count = mispred_count = 0.
  - Combinational outputs follow from this state, so after reset pred_taken=0 and pred_target=if_pc+4.
- Lookup (combinational, zero latency):
  - btb_idx = if_pc[IDX_W+1:2].
  - pred_idx = btb_idx XOR zero-extended GHR when HIST_BITS>0; otherwise pred_idx = btb_idx.
  - hit = valid[btb_idx] & (tag[btb_idx] == if_pc[31:IDX_W+2]).
  - pred_taken = hit & cnt[pred_idx][1].
  - pred_target = pred_taken ? btb_target[btb_idx] : if_pc+4 (modulo 2^32).
- Resolve (combinational):
  - mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - Both outputs are don't-care when ex_valid=0; mispredict must then be 0.
- Update (clk edge, ex_valid=1):
  - Conditional branch, counter: cnt[ex_idx] increments on taken and decrements on not-taken, saturating at 3 and 0.
  - Unconditional jump, counter: cnt[ex_idx] is set to 3.
  - BTB: written at ex_pc[IDX_W+1:2] only when ex_taken. Fields: valid=1, tag=ex_pc[31:IDX_W+2], target=ex_target. An existing entry with a different tag is overwritten (no replacement policy).
  - GHR: for conditional branches only, GHR <= {GHR[HIST_BITS-2:0], ex_taken}. GHR is non-speculative (updated at resolve only).
  - branch_count increments by 1 and saturates at 32'hFFFF_FFFF.
  - mispred_count increments by 1 when mispredict=1, saturating at the same value.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update (old) value; there is no bypass.
- rst asserted together with ex_valid: reset wins; no training happens.
- ex_idx is used verbatim, so a stale GHR at fetch time cannot mis-train a different entry than the one predicted from.

Decomposition:
- Package bp_pkg:
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Saturating-increment/decrement function.
  - Tag-width calculation: 30-IDX_W.
- One sub-module, bp_btb: valid/tag/target arrays with a combinational read port and a synchronous write port.
- Counters, GHR and performance counters stay in the top level.

Test Plan:
- Reset, then if_pc=0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014; both counters read 0.
- Branch at 0x0040_0020, target 0x0040_0000, resolved taken twice -> counter goes 01→10→11. The next lookup gives pred_taken=1, pred_target=0x0040_0000, and the first resolve asserted mispredict=1.
- Counter at 11, three not-taken resolves -> counter 10, 01, 00 (saturates at 00). The first not-taken resolve asserts mispredict with redirect_pc=0x0040_0024.
- Jump at 0x0040_0030 to 0x0040_1000, resolved once -> counter=11 and BTB hit. An alias PC 0x0040_0130 with ENTRIES=64 misses on tag: pred_taken=0.
- HIST_BITS=4, alternating T/N pattern on one branch for 20 resolves -> mispred_count stops incrementing after warm-up, and the GHR is non-zero.
- ex_valid and lookup on the same index in one cycle -> lookup shows the old counter value; the next cycle shows the updated value. With rst asserted alongside ex_valid, all state is reset.
